register_file: RTL and testbench
================================

# register_file

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit port and alongside the decoder's issue path. It holds the 32 committed integer register values, records which in-flight ROB entry will produce each register's next value, and answers the decoder's two source-operand lookups with either a value or a producer tag. It retires values on ROB commit and drops all rename state on rollback.

## Interface
- `ROB_TAG_WIDTH`, 4: width of a ROB tag. Tag 0 is the null tag, "no pending producer".
- `XLEN`, 32: data word width.
- `REG_COUNT`, 32: number of architectural registers. The register index is 5 bits.

Ports:
- `clk`  in  1  the single clock. All state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rollback_in`  in  1  misprediction flush from the ROB.
- `commit_signal_in`  in  1  the ROB is retiring one entry this cycle.
- `commit_tag_in`  in  `ROB_TAG_WIDTH`  tag of the retiring entry.
- `commit_data_in`  in  `XLEN`  result of the retiring entry.
- `commit_target_in`  in  5  destination register of the retiring entry. A value of 0 means no destination.
- `dec_issue_in`  in  1  the decoder is issuing one instruction this cycle.
- `dec_rd_in`  in  5  destination register of the issued instruction. It is 0 for stores and branches.
- `dec_tag_in`  in  `ROB_TAG_WIDTH`  ROB tag allocated to the issued instruction. This is the ROB's next-tag output.
- `dec_rs1_in`, `dec_rs2_in`  in  5 each  source register indices.
- `dec_Vj_out`, `dec_Vk_out`  out  `XLEN` each  source values. They are valid only when the matching Q output is 0.
- `dec_Qj_out`, `dec_Qk_out`  out  `ROB_TAG_WIDTH` each  producer tags, or 0 if the value is final.

## Operation
- State:
  - `value[1..31]` of `XLEN` bits.
  - `tag[1..31]` of `ROB_TAG_WIDTH` bits.
  - x0 has no storage. It always reads as value 0 with tag 0.
- Commit: when `commit_signal_in` is high and `commit_target_in` is not 0:
  - `value[target]` is set to `commit_data_in`.
  - `tag[target]` is cleared to 0 only if it equals `commit_tag_in`. Otherwise a younger producer still owns the register and the tag is kept.
- Issue: when `dec_issue_in` is high and `dec_rd_in` is not 0:
  - `tag[rd]` is set to `dec_tag_in`.
  - The value is untouched.
- Commit and issue to the same register in the same cycle: the commit writes the value, and the issue's new tag wins.
- Rollback: when `rollback_in` is high:
  - All tags are cleared to 0.
  - Values are kept, including a commit arriving in the same cycle. That commit's data is written, because the ROB asserts rollback together with the commit of the mispredicted JALR or branch.
  - Any issue in a rollback cycle is ignored.
- Read, one port per source, fully combinational:
  - If rs is 0: V=0, Q=0.
  - Else, if `tag[rs]` is not 0, commit is high, and `commit_tag_in` equals `tag[rs]`: forward the commit, so V=`commit_data_in` and Q=0.
  - Else: V=`value[rs]`, Q=`tag[rs]`.
- Reads see pre-issue state. The decoder resolves intra-instruction hazards (rs equal to rd of the same instruction) by reading before the issue is applied, which is automatic since updates land at the clock edge.
- The block never stalls. Back-pressure is handled entirely by the ROB's full output gating `dec_issue_in`.

## Timing
- Reset: asserting `rst_n` low immediately, asynchronously, sets all values and tags to 0. All V/Q outputs are therefore 0 during and after reset.
- Commit write latency: 1 cycle into storage. Forwarding makes the value visible to a lookup in the same cycle as the commit.
- Issue rename: visible to lookups from the cycle after `dec_issue_in`.
- Rollback: all Q outputs read 0 from the cycle after `rollback_in`.
- Reset deasserted mid-stream: there is no pending-state recovery. Upstream blocks reset together.

## Structure
- Shared header:
  - `WORD_RANGE`, `REG_INDEX_RANGE`, `ROB_TAG_RANGE`.
  - `NULL_TAG` (0), `ZERO_WORD`, `ZERO_REG_INDEX`.
  - These are the same definitions the ROB and decoder use.
- Sub-module `register_read_port`: the combinational lookup and commit-forward mux. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- Reset, then read rs1=5, rs2=0 -> V=0/Q=0 on both ports. Issue rd=0 with tag 3 -> reading x0 still gives Q=0.
- Issue rd=5 with tag 3. Next cycle read x5 -> Q=3. Commit tag 3, target 5, data 0xDEADBEEF -> the same-cycle read gives V=0xDEADBEEF, Q=0. The next cycle gives the same value from storage.
- Issue rd=7 tag 2, then rd=7 tag 4. Commit tag 2, data 0x11 -> x7 value 0x11, Q stays 4. Commit tag 4, data 0x22 -> Q=0, V=0x22.
- Same cycle: commit tag 2 to x9 with data 0x55, and issue rd=9 tag 6 -> the next read gives V=0x55, Q=6.
- Rename x1, x2, x3 with tags 1, 2, 3. Commit tag 1 to x1 with data 0xA0 plus `rollback_in`, and issue rd=4 in the same cycle -> next cycle x1=0xA0, all Q=0, and x4 is not renamed.
- Pulse `rst_n` low asynchronously between clock edges with renames pending -> outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared definitions for the register file, ROB and decoder.
//   - XLEN / ROB_TAG_WIDTH / REG_COUNT sizing constants
//   - word_t, reg_index_t, rob_tag_t carry the word, register-index and
//     ROB-tag ranges so every block slices them identically
//   - NULL_TAG (tag 0 = "no pending producer"), ZERO_WORD, ZERO_REG_INDEX
package register_file_pkg;

  localparam int ROB_TAG_WIDTH   = 4;
  localparam int XLEN            = 32;
  localparam int REG_COUNT       = 32;
  localparam int REG_INDEX_WIDTH = $clog2(REG_COUNT);

  typedef logic [XLEN-1:0]            word_t;
  typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;
  typedef logic [ROB_TAG_WIDTH-1:0]   rob_tag_t;

  localparam rob_tag_t   NULL_TAG       = '0;
  localparam word_t      ZERO_WORD      = '0;
  localparam reg_index_t ZERO_REG_INDEX = '0;

endpackage

// File: rtl/register_read_port.sv
// register_read_port: one combinational source-operand lookup.
//   rs            in   source register index
//   values, tags  in   flattened register state (entry 0 is x0)
//   commit_*      in   the ROB commit presented this cycle
//   v, q          out  source value and producer tag (v meaningful when q == 0)
// x0 reads as value 0 / tag 0. A register whose producer is retiring in this
// very cycle is forwarded from the commit bus so the decoder never waits a
// cycle for a value that is already known.
module register_read_port
  import register_file_pkg::*;
(
  input  logic [REG_INDEX_WIDTH-1:0]              rs,
  input  logic [REG_COUNT-1:0][XLEN-1:0]          values,
  input  logic [REG_COUNT-1:0][ROB_TAG_WIDTH-1:0] tags,
  input  logic                                    commit_signal,
  input  logic [ROB_TAG_WIDTH-1:0]                commit_tag,
  input  logic [XLEN-1:0]                         commit_data,
  output logic [XLEN-1:0]                         v,
  output logic [ROB_TAG_WIDTH-1:0]                q
);

  logic [ROB_TAG_WIDTH-1:0] src_tag;

  assign src_tag = tags[rs];

  always_comb begin
    v = ZERO_WORD;
    q = NULL_TAG;
    if (rs != ZERO_REG_INDEX) begin
      if ((src_tag != NULL_TAG) && commit_signal && (commit_tag == src_tag)) begin
        v = commit_data;
        q = NULL_TAG;
      end else begin
        v = values[rs];
        q = src_tag;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file: architectural integer registers with per-register rename tags.
//   clk, rst_n            clock; asynchronous active-low reset (clears all state)
//   rollback_in           flush: clears every tag, blocks the same-cycle issue
//   commit_*_in           ROB retirement: writes value, clears a matching tag
//   dec_issue_in/rd/tag   decoder rename: records the producer tag of rd
//   dec_rs1_in/rs2_in     source lookups
//   dec_V*/Q*_out         source value or producer tag per source
// Commit and issue are valid-only strobes: the block has no ready output and
// accepts every strobe in the cycle it is presented; the ROB gates issue.
// Lookups are combinational and see the state before this cycle's edge.
module register_file
  import register_file_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rollback_in,
  input  logic                       commit_signal_in,
  input  logic [ROB_TAG_WIDTH-1:0]   commit_tag_in,
  input  logic [XLEN-1:0]            commit_data_in,
  input  logic [REG_INDEX_WIDTH-1:0] commit_target_in,
  input  logic                       dec_issue_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rd_in,
  input  logic [ROB_TAG_WIDTH-1:0]   dec_tag_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rs1_in,
  input  logic [REG_INDEX_WIDTH-1:0] dec_rs2_in,
  output logic [XLEN-1:0]            dec_Vj_out,
  output logic [XLEN-1:0]            dec_Vk_out,
  output logic [ROB_TAG_WIDTH-1:0]   dec_Qj_out,
  output logic [ROB_TAG_WIDTH-1:0]   dec_Qk_out
);

  // Entry 0 is cleared by reset and never written, so x0 stays value 0 / tag 0.
  logic [REG_COUNT-1:0][XLEN-1:0]          value_q;
  logic [REG_COUNT-1:0][ROB_TAG_WIDTH-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      tag_q   <= '0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (commit_signal_in && (commit_target_in == REG_INDEX_WIDTH'(i))) begin
          value_q[i] <= commit_data_in;
        end
        // Rollback beats everything; a same-cycle issue beats the commit's
        // tag clear; a commit only clears the tag if it is still the newest
        // producer of the register.
        if (rollback_in) begin
          tag_q[i] <= NULL_TAG;
        end else if (dec_issue_in && (dec_rd_in == REG_INDEX_WIDTH'(i))) begin
          tag_q[i] <= dec_tag_in;
        end else if (commit_signal_in && (commit_target_in == REG_INDEX_WIDTH'(i))
                     && (tag_q[i] == commit_tag_in)) begin
          tag_q[i] <= NULL_TAG;
        end
      end
    end
  end

  register_read_port u_read_rs1 (
    .rs            (dec_rs1_in),
    .values        (value_q),
    .tags          (tag_q),
    .commit_signal (commit_signal_in),
    .commit_tag    (commit_tag_in),
    .commit_data   (commit_data_in),
    .v             (dec_Vj_out),
    .q             (dec_Qj_out)
  );

  register_read_port u_read_rs2 (
    .rs            (dec_rs2_in),
    .values        (value_q),
    .tags          (tag_q),
    .commit_signal (commit_signal_in),
    .commit_tag    (commit_tag_in),
    .commit_data   (commit_data_in),
    .v             (dec_Vk_out),
    .q             (dec_Qk_out)
  );

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        rollback;
  logic        commit_signal;
  logic [3:0]  commit_tag;
  logic [31:0] commit_data;
  logic [4:0]  commit_target;
  logic        dec_issue;
  logic [4:0]  dec_rd;
  logic [3:0]  dec_tag;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_vj;
  logic [31:0] dec_vk;
  logic [3:0]  dec_qj;
  logic [3:0]  dec_qk;

  int vectors;
  int miscompares;

  // Reference state: architectural value and pending-producer tag per register.
  logic [31:0] m_val [32];
  logic [3:0]  m_tag [32];

  register_file dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rollback_in      (rollback),
    .commit_signal_in (commit_signal),
    .commit_tag_in    (commit_tag),
    .commit_data_in   (commit_data),
    .commit_target_in (commit_target),
    .dec_issue_in     (dec_issue),
    .dec_rd_in        (dec_rd),
    .dec_tag_in       (dec_tag),
    .dec_rs1_in       (dec_rs1),
    .dec_rs2_in       (dec_rs2),
    .dec_Vj_out       (dec_vj),
    .dec_Vk_out       (dec_vk),
    .dec_Qj_out       (dec_qj),
    .dec_Qk_out       (dec_qk)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'd0;
      m_tag[i] = 4'd0;
    end
  endtask

  // Value/tag a lookup of rs should return given the commit on the bus now.
  task automatic model_read(input logic [4:0] rs, output logic [31:0] v, output logic [3:0] q);
    if (rs == 5'd0) begin
      v = 32'd0;
      q = 4'd0;
    end else if (m_tag[rs] != 4'd0 && commit_signal && commit_tag == m_tag[rs]) begin
      v = commit_data;
      q = 4'd0;
    end else begin
      v = m_val[rs];
      q = m_tag[rs];
    end
  endtask

  // Architectural effect of one clock edge with the inputs currently driven.
  task automatic model_update();
    logic commit_hits;
    commit_hits = commit_signal && commit_target != 5'd0;
    if (commit_hits) m_val[commit_target] = commit_data;
    if (rollback) begin
      for (int i = 0; i < 32; i++) m_tag[i] = 4'd0;
    end else begin
      if (commit_hits && m_tag[commit_target] == commit_tag) m_tag[commit_target] = 4'd0;
      if (dec_issue && dec_rd != 5'd0) m_tag[dec_rd] = dec_tag;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [31:0] ev;
    logic [3:0]  eq;
    model_read(dec_rs1, ev, eq);
    check({name, "_vj"}, dec_vj, ev);
    check({name, "_qj"}, {28'd0, dec_qj}, {28'd0, eq});
    model_read(dec_rs2, ev, eq);
    check({name, "_vk"}, dec_vk, ev);
    check({name, "_qk"}, {28'd0, dec_qk}, {28'd0, eq});
  endtask

  // ---------------- drivers ----------------
  // Called just after a falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic rb, input logic cs, input logic [3:0] ctag,
                       input logic [31:0] cdata, input logic [4:0] ctgt,
                       input logic iss, input logic [4:0] rd, input logic [3:0] itag,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    rollback      = rb;
    commit_signal = cs;
    commit_tag    = ctag;
    commit_data   = cdata;
    commit_target = ctgt;
    dec_issue     = iss;
    dec_rd        = rd;
    dec_tag       = itag;
    dec_rs1       = rs1;
    dec_rs2       = rs2;
    #1;
  endtask

  task automatic read_only(input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 5'd0, 4'd0, rs1, rs2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        r_rb, r_cs, r_iss;
    logic [3:0]  r_ctag, r_itag;
    logic [4:0]  r_tgt, r_rd, r_rs1, r_rs2;
    logic [31:0] r_data;

    vectors     = 0;
    miscompares = 0;
    model_clear();
    rst_n = 1'b0;
    read_only(5'd5, 5'd0);
    @(negedge clk);
    @(negedge clk);
    check_model("in_reset");
    rst_n = 1'b1;

    // Reset state and x0 immunity to renaming.
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd0, 4'd3, 5'd5, 5'd0);
    check_model("after_reset");
    check("after_reset_qj_const", {28'd0, dec_qj}, 32'd0);
    tick();
    read_only(5'd0, 5'd0);
    check_model("x0_after_issue");
    check("x0_q_const", {28'd0, dec_qj}, 32'd0);
    tick();

    // Rename, then commit with same-cycle forwarding.
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd5, 4'd3, 5'd0, 5'd0);
    tick();
    read_only(5'd5, 5'd0);
    check_model("x5_renamed");
    check("x5_q3", {28'd0, dec_qj}, 32'd3);
    tick();
    drive(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 5'd5, 1'b0, 5'd0, 4'd0, 5'd5, 5'd5);
    check_model("x5_forward");
    check("x5_fwd_v", dec_vj, 32'hDEADBEEF);
    check("x5_fwd_q", {28'd0, dec_qj}, 32'd0);
    tick();
    read_only(5'd5, 5'd0);
    check_model("x5_stored");
    check("x5_stored_v", dec_vj, 32'hDEADBEEF);
    tick();

    // Older commit must not clear a younger producer's tag.
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd7, 4'd2, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd7, 4'd4, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 4'd2, 32'h11, 5'd7, 1'b0, 5'd0, 4'd0, 5'd7, 5'd0);
    check_model("x7_old_commit");
    tick();
    read_only(5'd7, 5'd0);
    check_model("x7_younger");
    check("x7_v11", dec_vj, 32'h11);
    check("x7_q4", {28'd0, dec_qj}, 32'd4);
    tick();
    drive(1'b0, 1'b1, 4'd4, 32'h22, 5'd7, 1'b0, 5'd0, 4'd0, 5'd0, 5'd7);
    check_model("x7_fwd");
    tick();
    read_only(5'd0, 5'd7);
    check("x7_v22", dec_vk, 32'h22);
    check("x7_q0", {28'd0, dec_qk}, 32'd0);
    tick();

    // Commit and issue to the same register in one cycle.
    drive(1'b0, 1'b1, 4'd2, 32'h55, 5'd9, 1'b1, 5'd9, 4'd6, 5'd0, 5'd0);
    tick();
    read_only(5'd9, 5'd9);
    check_model("x9_both");
    check("x9_v55", dec_vj, 32'h55);
    check("x9_q6", {28'd0, dec_qj}, 32'd6);
    tick();

    // Rollback with a same-cycle commit and an ignored issue.
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd1, 4'd1, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd2, 4'd2, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd3, 4'd3, 5'd2, 5'd3);
    check_model("pre_rollback");
    tick();
    drive(1'b1, 1'b1, 4'd1, 32'hA0, 5'd1, 1'b1, 5'd4, 4'd5, 5'd1, 5'd2);
    check_model("rollback_cycle");
    tick();
    read_only(5'd1, 5'd4);
    check_model("post_rollback_a");
    check("x1_vA0", dec_vj, 32'hA0);
    check("x4_q0", {28'd0, dec_qk}, 32'd0);
    tick();
    read_only(5'd2, 5'd3);
    check_model("post_rollback_b");
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r_rb  = ($urandom_range(0, 19) == 0);
      r_cs  = $urandom_range(0, 1);
      r_tgt = 5'($urandom_range(0, 31));
      r_ctag = (($urandom_range(0, 3) != 0) && m_tag[r_tgt] != 4'd0) ? m_tag[r_tgt]
                                                                     : 4'($urandom_range(1, 15));
      r_data = $urandom;
      r_iss  = $urandom_range(0, 1);
      r_rd   = 5'($urandom_range(0, 31));
      r_itag = 4'($urandom_range(1, 15));
      r_rs1  = ($urandom_range(0, 1) != 0) ? r_tgt : 5'($urandom_range(0, 31));
      r_rs2  = 5'($urandom_range(0, 31));
      drive(r_rb, r_cs, r_ctag, r_data, r_tgt, r_iss, r_rd, r_itag, r_rs1, r_rs2);
      check_model("random");
      tick();
    end

    // Asynchronous reset between clock edges with renames pending.
    drive(1'b0, 1'b0, 4'd0, 32'd0, 5'd0, 1'b1, 5'd10, 4'd7, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 4'd9, 32'h1234, 5'd12, 1'b1, 5'd11, 4'd8, 5'd0, 5'd0);
    tick();
    read_only(5'd10, 5'd12);
    check_model("pre_async_reset");
    check("x10_q7", {28'd0, dec_qj}, 32'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_vj", dec_vj, 32'd0);
    check("async_qj", {28'd0, dec_qj}, 32'd0);
    check("async_vk", dec_vk, 32'd0);
    check("async_qk", {28'd0, dec_qk}, 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    read_only(5'd11, 5'd12);
    check_model("post_async_reset");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
